split_addsub_seq: RTL and testbench

//  Sequential 16-bit add/subtract engine for the calculator datapath. It

---
 rtl/split_addsub_seq.sv | 146 ++++++++++++++
 tb/tb_split_addsub_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/split_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : split_addsub_seq
// Brief    : 16-bit add/subtract done as two 8-bit passes, low half first,
//            with the low-half carry chained into the high half.
// Revision : 1.0 - initial release
// ============================================================================
module split_addsub_seq #(
  parameter int WIDTH = 16,
  parameter int HALF  = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             islow,
  output logic [2:0]       op_sign,
  output logic             half_carry,
  output logic             op_err
);

  localparam logic [2:0] C_OP_ADD = 3'd3;
  localparam logic [2:0] C_OP_SUB = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_sign;
  logic [HALF-1:0]  r_lo;
  logic             r_c8;
  logic             r_err;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;

  logic             w_valid_in;
  logic             w_sub;
  logic [HALF-1:0]  w_bl;
  logic [HALF-1:0]  w_bh;
  logic [HALF:0]    w_lo_sum;
  logic [HALF:0]    w_hi_sum;

  assign w_valid_in = (sign == C_OP_ADD) || (sign == C_OP_SUB);
  assign w_sub      = (r_sign == C_OP_SUB);

  // Subtraction is A + ~B + 1: invert B and inject the +1 as low-half carry-in.
  assign w_bl     = w_sub ? ~r_b[HALF-1:0] : r_b[HALF-1:0];
  assign w_bh     = w_sub ? ~r_b[WIDTH-1:HALF] : r_b[WIDTH-1:HALF];
  assign w_lo_sum = {1'b0, r_a[HALF-1:0]} + {1'b0, w_bl} + {{HALF{1'b0}}, w_sub};
  assign w_hi_sum = {1'b0, r_a[WIDTH-1:HALF]} + {1'b0, w_bh} + {{HALF{1'b0}}, r_c8};

  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    islow      = 1'b0;
    op_sign    = 3'd0;
    half_carry = 1'b0;
    op_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_valid_in ? S_LOW : S_DONE;
        end
      end
      S_LOW: begin
        busy       = 1'b1;
        islow      = 1'b1;
        op_sign    = r_sign;
        half_carry = w_lo_sum[HALF];
        w_next     = S_HIGH;
      end
      S_HIGH: begin
        busy       = 1'b1;
        op_sign    = r_sign;
        half_carry = w_hi_sum[HALF];
        w_next     = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        op_sign = r_sign;
        op_err  = r_err;
        w_next  = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sign   <= 3'd0;
      r_lo     <= '0;
      r_c8     <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_sign <= sign;
            r_err  <= !w_valid_in;
          end
        end
        S_LOW: begin
          r_lo <= w_lo_sum[HALF-1:0];
          r_c8 <= w_lo_sum[HALF];
        end
        S_HIGH: begin
          // For subtract the adder carry is "no borrow"; flip it to a borrow flag.
          r_result <= {w_hi_sum[HALF-1:0], r_lo};
          r_carry  <= w_sub ? ~w_hi_sum[HALF] : w_hi_sum[HALF];
        end
        default: begin
        end
      endcase
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_split_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_split_addsub_seq
// Brief    : Self-checking bench: vector table, hand sequences, random ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_split_addsub_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  sign;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry_out;
  logic        islow;
  logic [2:0]  op_sign;
  logic        half_carry;
  logic        op_err;

  int errors;
  int checks;

  logic [15:0] m_res;
  logic        m_co;

  split_addsub_seq #(.WIDTH(16), .HALF(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sign       (sign),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_out  (carry_out),
    .islow      (islow),
    .op_sign    (op_sign),
    .half_carry (half_carry),
    .op_err     (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  s;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] exp_res;
    logic        exp_co;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word arithmetic; half carries from the operand halves.
  task automatic model(input logic [2:0] s, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] res, output logic co,
                       output logic hl, output logic hh);
    int sx, sy, slx, sly;
    sx  = int'(x);
    sy  = int'(y);
    slx = int'(x[7:0]);
    sly = int'(y[7:0]);
    if (s == 3'd4) begin
      res = 16'((sx - sy) & 32'hFFFF);
      co  = (sx < sy);
      hl  = (slx >= sly);
      hh  = (sx >= sy);
    end else begin
      res = 16'((sx + sy) & 32'hFFFF);
      co  = (sx + sy) > 32'hFFFF;
      hl  = (slx + sly) > 255;
      hh  = co;
    end
  endtask

  task automatic run_op(input logic [2:0] s, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] exp_res, input logic exp_co, input bit disturb);
    logic [15:0] r_dummy;
    logic        co_dummy, hl, hh;
    bit          valid;
    valid = (s == 3'd3) || (s == 3'd4);
    model(s, x, y, r_dummy, co_dummy, hl, hh);
    sign = s; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sign = 3'($urandom);
    if (valid) begin
      chk("low_busy", 32'(busy), 32'd1);
      chk("low_islow", 32'(islow), 32'd1);
      chk("low_op_sign", 32'(op_sign), 32'(s));
      chk("low_half_carry", 32'(half_carry), 32'(hl));
      chk("low_done", 32'(done), 32'd0);
      if (disturb) start = 1'b1;
      tick();
      chk("high_islow", 32'(islow), 32'd0);
      chk("high_busy", 32'(busy), 32'd1);
      chk("high_half_carry", 32'(half_carry), 32'(hh));
      chk("high_op_sign", 32'(op_sign), 32'(s));
      tick();
      start = 1'b0;
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_result", 32'(result), 32'(exp_res));
      chk("done_carry", 32'(carry_out), 32'(exp_co));
      chk("done_op_err", 32'(op_err), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_half_carry", 32'(half_carry), 32'd0);
      m_res = exp_res;
      m_co  = exp_co;
    end else begin
      chk("inv_done", 32'(done), 32'd1);
      chk("inv_op_err", 32'(op_err), 32'd1);
      chk("inv_result", 32'(result), 32'(m_res));
      chk("inv_carry", 32'(carry_out), 32'(m_co));
      chk("inv_busy", 32'(busy), 32'd0);
      chk("inv_op_sign", 32'(op_sign), 32'(s));
    end
    tick();
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_op_err", 32'(op_err), 32'd0);
    chk("idle_op_sign", 32'(op_sign), 32'd0);
    chk("idle_hold_result", 32'(result), 32'(m_res));
    if (disturb) begin
      tick();
      chk("disturb_no_second_op", 32'(busy | done), 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  rs;
    logic [15:0] rx, ry, rres;
    logic        rco, rhl, rhh;
    errors = 0; checks = 0;
    m_res = 16'h0; m_co = 1'b0;
    rst_n = 1'b0; start = 1'b0; sign = 3'd0; a = 16'h0; b = 16'h0;

    vecs[0] = '{3'd3, 16'h00FF, 16'h0001, 16'h0100, 1'b0};
    vecs[1] = '{3'd3, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[2] = '{3'd4, 16'h1000, 16'h0001, 16'h0FFF, 1'b0};
    vecs[3] = '{3'd4, 16'h0001, 16'h0002, 16'hFFFF, 1'b1};
    vecs[4] = '{3'd4, 16'h1234, 16'h1234, 16'h0000, 1'b0};
    vecs[5] = '{3'd3, 16'h1234, 16'h4321, 16'h5555, 1'b0};
    vecs[6] = '{3'd4, 16'h0000, 16'hFFFF, 16'h0001, 1'b1};
    vecs[7] = '{3'd3, 16'h8000, 16'h8000, 16'h0000, 1'b1};

    tick(); tick();
    chk("rst_outputs", {18'd0, busy, done, result[7:0], carry_out, islow, half_carry, op_err},
        32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_op_sign", 32'(op_sign), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].exp_res, vecs[i].exp_co, 1'b0);
    end

    // Restarts during LOW/HIGH must be ignored.
    run_op(3'd3, 16'h0102, 16'h0304, 16'h0406, 1'b0, 1'b1);

    // Invalid op codes keep the previous result.
    run_op(3'd5, 16'hAAAA, 16'h5555, 16'h0, 1'b0, 1'b0);
    run_op(3'd0, 16'h1111, 16'h2222, 16'h0, 1'b0, 1'b0);

    // start held high: new op accepted in first IDLE cycle after DONE.
    sign = 3'd3; a = 16'h0001; b = 16'h0001; start = 1'b1;
    tick(); tick(); tick();
    chk("hold_done1", 32'(done), 32'd1);
    chk("hold_result1", 32'(result), 32'h0002);
    a = 16'h0005; b = 16'h0005;
    tick();
    chk("hold_idle_gap", 32'(busy | done), 32'd0);
    tick();
    start = 1'b0;
    chk("hold_accept", 32'(islow), 32'd1);
    tick(); tick();
    chk("hold_done2", 32'(done), 32'd1);
    chk("hold_result2", 32'(result), 32'h000A);
    tick();
    m_res = 16'h000A; m_co = 1'b0;

    // Reset during HIGH aborts at once.
    sign = 3'd3; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_in_high", 32'(busy & ~islow), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {26'd0, busy, done, carry_out, islow, half_carry, op_err}, 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_op_sign", 32'(op_sign), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    m_res = 16'h0; m_co = 1'b0;
    run_op(3'd3, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      rs = ($urandom_range(0, 7) == 0) ? 3'($urandom) : (($urandom & 1) ? 3'd4 : 3'd3);
      rx = 16'($urandom);
      ry = ($urandom_range(0, 9) == 0) ? rx : 16'($urandom);
      model(rs, rx, ry, rres, rco, rhl, rhh);
      run_op(rs, rx, ry, rres, rco, bit'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
